itrx_apb3_master: RTL

- Parametrised AMBA3 APB requester. Converts a valid/ready command stream from an internal controller (register sequencer, debug port) into APB3 transfers. Returns read data and error status on a response stream.
- Supports configurable address/data width, PREADY wait states, PSLVERR capture, and a programmable wait-state timeout that aborts hung transfers.
- Sits between the on-chip controller and the APB peripheral fabric.

---
 rtl/itrx_apb3_master.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/itrx_apb3_master.sv
`default_nettype none
// ============================================================================
// Module   : itrx_apb3_master
// Purpose  : AMBA3 APB requester. Takes one command at a time from a
//            valid/ready stream, runs it as an APB3 SETUP/ACCESS transfer,
//            and returns read data and error status on a response stream.
//            Hung transfers can be aborted by a programmable wait-state
//            timeout.
// Params   : AW   - address width
//            DW   - data width (8, 16 or 32)
//            TO_W - timeout counter / limit width
// Ports    : i_clk, i_rst_n            clock, async active-low reset
//            i_cmd_* / o_cmd_ready     command stream (write, addr, wdata)
//            o_rsp_* / i_rsp_ready     response stream (rdata, err, timeout)
//            i_to_limit                max ACCESS wait cycles, 0 = no limit
//            o_psel .. o_pwdata        APB requester outputs
//            i_prdata, i_pready,
//            i_pslverr                 APB completer inputs
// Revision : 1.0 - initial release
// ============================================================================
module itrx_apb3_master #(
  parameter int AW   = 12,
  parameter int DW   = 32,
  parameter int TO_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_write,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_rsp_timeout,
  input  logic [TO_W-1:0] i_to_limit,
  output logic            o_psel,
  output logic            o_penable,
  output logic            o_pwrite,
  output logic [AW-1:0]   o_paddr,
  output logic [DW-1:0]   o_pwdata,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pready,
  input  logic            i_pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [TO_W:0] c_CNT_ONE = (TO_W+1)'(1);

  state_t          r_state;
  state_t          w_next;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;
  logic            r_rsp_timeout;
  logic [TO_W-1:0] r_cnt;

  logic            w_cmd_hs;
  logic            w_done;
  logic            w_abort;
  logic            w_limit_on;
  logic [TO_W:0]   w_cnt_next;
  logic            w_cmd_ready;
  logic            w_psel;
  logic            w_penable;
  logic            w_rsp_valid;

  assign w_cmd_hs   = (r_state == S_IDLE) && i_cmd_valid;
  assign w_limit_on = (i_to_limit != '0);
  // One bit wider so the compare never overflows at the top of the range.
  assign w_cnt_next = {1'b0, r_cnt} + c_CNT_ONE;
  // pready has priority: a limit reached in the same cycle as pready still
  // completes normally. The >= (rather than ==) makes a limit lowered below
  // the running count mid-transfer abort at once instead of never.
  assign w_done  = (r_state == S_ACCESS) && i_pready;
  assign w_abort = (r_state == S_ACCESS) && !i_pready && w_limit_on &&
                   (w_cnt_next >= {1'b0, i_to_limit});

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (i_cmd_valid) w_next = S_SETUP;
      end
      S_SETUP: begin
        w_psel = 1'b1;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (w_done || w_abort) w_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture and response registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_pwrite <= i_cmd_write;
        r_paddr  <= i_cmd_addr;
        // Reads leave pwdata alone so the bus does not toggle needlessly.
        if (i_cmd_write) r_pwdata <= i_cmd_wdata;
      end
      if (w_done) begin
        r_rsp_rdata   <= r_pwrite ? '0 : i_prdata;
        r_rsp_err     <= i_pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  // Wait-state counter: cleared in SETUP, saturating in ACCESS
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !i_pready && w_limit_on &&
                 !w_abort && (r_cnt != '1)) begin
      r_cnt <= w_cnt_next[TO_W-1:0];
    end
  end

  assign o_cmd_ready   = w_cmd_ready;
  assign o_psel        = w_psel;
  assign o_penable     = w_penable;
  assign o_rsp_valid   = w_rsp_valid;
  assign o_pwrite      = r_pwrite;
  assign o_paddr       = r_paddr;
  assign o_pwdata      = r_pwdata;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_timeout = r_rsp_timeout;

`ifndef SYNTHESIS
  a_penable_psel : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_penable |-> o_psel);
  a_bus_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_psel && $past(o_psel)) |->
      ($stable(o_paddr) && $stable(o_pwrite) && $stable(o_pwdata)));
  a_rsp_hold : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $past(o_rsp_valid && !i_rsp_ready) |-> o_rsp_valid);
`endif

endmodule
`default_nettype wire
